// File: rtl/ras_stack.sv
// Return-address stack: entry 0 is the top, read combinationally; push/pop shift the entry array.
// Optional CVA6_RAS_STATS_EN adds saturating overflow/underflow event counters.
module ras_stack #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned VLEN  = 64,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [VLEN-1:0]  data_i,
  output logic             valid_o,
  output logic [VLEN-1:0]  ra_o,
  output logic [OCC_W-1:0] occupancy_o
`ifdef CVA6_RAS_STATS_EN
  ,
  output logic [7:0]       overflow_cnt_o,
  output logic [7:0]       underflow_cnt_o
`endif
);

  logic             r_valid [DEPTH];
  logic [VLEN-1:0]  r_addr  [DEPTH];
  logic [OCC_W-1:0] r_occ;

  logic             w_dn_valid [DEPTH];
  logic [VLEN-1:0]  w_dn_addr  [DEPTH];
  logic             w_up_valid [DEPTH];
  logic [VLEN-1:0]  w_up_addr  [DEPTH];
  logic             w_valid_next [DEPTH];
  logic [VLEN-1:0]  w_addr_next  [DEPTH];
  logic [OCC_W-1:0] w_occ_next;

  logic w_full;
  logic w_empty;

  assign w_full  = (r_occ == OCC_W'(DEPTH));
  assign w_empty = (r_occ == '0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Shift-down source (push) and shift-up source (pop) for this slot.
      if (gi == 0) begin : g_top
        assign w_dn_valid[gi] = 1'b1;
        assign w_dn_addr[gi]  = data_i;
      end else begin : g_below
        assign w_dn_valid[gi] = r_valid[gi-1];
        assign w_dn_addr[gi]  = r_addr[gi-1];
      end

      if (gi == DEPTH - 1) begin : g_bottom
        assign w_up_valid[gi] = 1'b0;
        assign w_up_addr[gi]  = '0;
      end else begin : g_above
        assign w_up_valid[gi] = r_valid[gi+1];
        assign w_up_addr[gi]  = r_addr[gi+1];
      end

      always_comb begin
        w_valid_next[gi] = r_valid[gi];
        w_addr_next[gi]  = r_addr[gi];
        if (flush_i) begin
          w_valid_next[gi] = 1'b0;
        end else if (push_i && pop_i) begin
          if (gi == 0) begin
            w_valid_next[gi] = 1'b1;
            w_addr_next[gi]  = data_i;
          end
        end else if (push_i) begin
          w_valid_next[gi] = w_dn_valid[gi];
          w_addr_next[gi]  = w_dn_addr[gi];
        end else if (pop_i) begin
          w_valid_next[gi] = w_up_valid[gi];
          w_addr_next[gi]  = w_up_addr[gi];
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_valid[gi] <= 1'b0;
          r_addr[gi]  <= '0;
        end else begin
          r_valid[gi] <= w_valid_next[gi];
          r_addr[gi]  <= w_addr_next[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    w_occ_next = r_occ;
    if (flush_i) begin
      w_occ_next = '0;
    end else if (push_i && pop_i) begin
      if (w_empty) w_occ_next = OCC_W'(1);
    end else if (push_i) begin
      if (!w_full) w_occ_next = r_occ + OCC_W'(1);
    end else if (pop_i) begin
      if (!w_empty) w_occ_next = r_occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_occ <= '0;
    else         r_occ <= w_occ_next;
  end

  assign valid_o     = r_valid[0];
  assign ra_o        = r_addr[0];
  assign occupancy_o = r_occ;

`ifdef CVA6_RAS_STATS_EN
  logic [7:0] r_ovf_cnt;
  logic [7:0] r_unf_cnt;
  logic       w_ovf_evt;
  logic       w_unf_evt;

  // A flushed cycle never performs its push or pop, so it is not an event.
  assign w_ovf_evt = !flush_i && push_i && !pop_i && w_full;
  assign w_unf_evt = !flush_i && pop_i && !push_i && w_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else begin
      if (w_ovf_evt && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
      if (w_unf_evt && r_unf_cnt != 8'hFF) r_unf_cnt <= r_unf_cnt + 8'd1;
    end
  end

  assign overflow_cnt_o  = r_ovf_cnt;
  assign underflow_cnt_o = r_unf_cnt;
`endif

endmodule
